// File: rtl/comparator_serial.sv
// Serial signed comparator, MS chunk first, valid/ready on both sides.
// Optional: COMPARATOR_SERIAL_EARLY_EXIT_EN ends the scan at the first differing chunk.
module comparator_serial #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         o_valid,
  input  logic         o_ready,
  output logic         eq,
  output logic         lt,
  output logic         gt
);

  localparam int NCH = N / W;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] TOP = IW'(NCH - 1);

`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          eq_q, eq_d;
  logic          lt_q, lt_d;
  logic          gt_q, gt_d;

  logic [W-1:0]  ca, cb;
  logic          hit;
  logic          last;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;

    ca = a_q[idx_q*W +: W];
    cb = b_q[idx_q*W +: W];
    // Flipping the sign bit maps two's-complement order onto unsigned order
    if (idx_q == TOP) begin
      ca[W-1] = ~ca[W-1];
      cb[W-1] = ~cb[W-1];
    end
    hit  = !(lt_q || gt_q) && (ca != cb);
    last = (idx_q == '0);

    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          a_d     = a;
          b_d     = b;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          idx_d   = TOP;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (hit) begin
          lt_d = (ca < cb);
          gt_d = (ca > cb);
        end
        if (last) begin
          eq_d    = !(lt_q || gt_q || hit);
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
        if (EARLY && hit) state_d = DONE;
      end
      DONE: begin
        if (o_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= TOP;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
    end
  end

  assign i_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign eq      = eq_q;
  assign lt      = lt_q;
  assign gt      = gt_q;

endmodule
